// File: rtl/vending_machine_param.sv
// Vending controller: accumulates coin credit, pulses sell at PRICE, then pays remainder as serial chg pulses.
// Latency: coin sampled at an edge takes effect after that edge; all outputs registered/state-decoded.
// Backpressure: busy during vend/payout; coins then are not credited and flagged via coin_rej. Optional refund: VM_CANCEL_EN.
module vending_machine_param #(
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                sell,
    output logic                chg,
    output logic                coin_rej,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam logic [CREDIT_W:0] PRICE_X = (CREDIT_W+1)'(PRICE);

    state_t              state, state_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic                rej_nxt;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;
    logic                cancel_hit;

`ifdef VM_CANCEL_EN
    assign cancel_hit = cancel && (state == ACCUM);
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign cancel_hit    = 1'b0;
`endif

    always_comb begin
        coin_val = '0;
        case (coin)
            2'b01:   coin_val = (CREDIT_W+1)'(1);
            2'b10:   coin_val = (CREDIT_W+1)'(2);
            2'b11:   coin_val = (CREDIT_W+1)'(10);
            default: coin_val = '0;
        endcase
    end

    // One extra bit so a 5-yuan coin on top of PRICE-1 credit cannot wrap before the compare.
    assign sum = {1'b0, credit} + coin_val;

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        rej_nxt    = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                if (cancel_hit) begin
                    state_nxt = CHANGE;
                    rej_nxt   = (coin != 2'b00);
                end else if (coin != 2'b00) begin
                    if (sum < PRICE_X) begin
                        state_nxt  = ACCUM;
                        credit_nxt = CREDIT_W'(sum);
                    end else begin
                        state_nxt  = VEND;
                        credit_nxt = CREDIT_W'(sum - PRICE_X);
                    end
                end
            end
            VEND: begin
                rej_nxt   = (coin != 2'b00);
                state_nxt = (credit == '0) ? IDLE : CHANGE;
            end
            CHANGE: begin
                rej_nxt = (coin != 2'b00);
                if (credit == CREDIT_W'(1)) begin
                    state_nxt  = IDLE;
                    credit_nxt = '0;
                end else begin
                    credit_nxt = credit - CREDIT_W'(1);
                end
            end
            default: begin
                state_nxt  = IDLE;
                credit_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            credit   <= '0;
            coin_rej <= 1'b0;
        end else begin
            state    <= state_nxt;
            credit   <= credit_nxt;
            coin_rej <= rej_nxt;
        end
    end

    assign sell = (state == VEND);
    assign chg  = (state == CHANGE);
    assign busy = (state == VEND) || (state == CHANGE);

endmodule

// File: tb/tb_vending_machine_param.sv
// Randomized and directed bench for vending_machine_param against a queue-based payout model.
module tb_vending_machine_param;

    localparam int PRICE    = 3;
    localparam int CREDIT_W = 4;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic [1:0]          coin = 2'b00;
    logic                cancel = 1'b0;
    logic                sell, chg, coin_rej, busy;
    logic [CREDIT_W-1:0] credit;

    vending_machine_param #(.PRICE(PRICE), .CREDIT_W(CREDIT_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .coin     (coin),
        .cancel   (cancel),
        .sell     (sell),
        .chg      (chg),
        .coin_rej (coin_rej),
        .busy     (busy),
        .credit   (credit)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: accepted credit while idle, plus a queue of scheduled output cycles {sell, credit} during payout.
    typedef struct { bit s; int cr; } ev_t;
    ev_t q[$];
    int  m_credit = 0;
    bit  m_rej = 0;
`ifdef VM_CANCEL_EN
    localparam bit CANCEL_EN = 1'b1;
`else
    localparam bit CANCEL_EN = 1'b0;
`endif

    int cnt_sell, cnt_chg, cnt_busy, cnt_rej;

    function automatic int coin_units(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 10;
            default: return 0;
        endcase
    endfunction

    task automatic schedule_payout(input bit with_sell, input int amount);
        ev_t e;
        if (with_sell) begin
            e.s = 1; e.cr = amount; q.push_back(e);
        end
        for (int k = amount; k >= 1; k--) begin
            e.s = 0; e.cr = k; q.push_back(e);
        end
    endtask

    task automatic model_step(input logic [1:0] c, input logic can);
        int sum;
        if (q.size() > 0) begin
            void'(q.pop_front());
            m_rej = (c != 2'b00);
        end else if (CANCEL_EN && can && m_credit > 0) begin
            schedule_payout(0, m_credit);
            m_credit = 0;
            m_rej = (c != 2'b00);
        end else begin
            m_rej = 0;
            sum = m_credit + coin_units(c);
            if (sum < PRICE) m_credit = sum;
            else begin
                schedule_payout(1, sum - PRICE);
                m_credit = 0;
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_credit = 0;
        m_rej = 0;
    endtask

    task automatic check_outputs();
        bit es, ec, eb;
        int ecr;
        eb  = (q.size() > 0);
        es  = eb && q[0].s;
        ec  = eb && !q[0].s;
        ecr = eb ? q[0].cr : m_credit;
        chk("sell", int'(sell), int'(es));
        chk("chg", int'(chg), int'(ec));
        chk("busy", int'(busy), int'(eb));
        chk("credit", int'(credit), ecr);
        chk("coin_rej", int'(coin_rej), int'(m_rej));
        cnt_sell += int'(sell);
        cnt_chg  += int'(chg);
        cnt_busy += int'(busy);
        cnt_rej  += int'(coin_rej);
    endtask

    // Check the state produced by the previous edge, then drive inputs for the next edge.
    task automatic cyc(input logic [1:0] c, input logic can);
        @(negedge clk);
        check_outputs();
        coin   = c;
        cancel = can;
        model_step(c, can);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(2'b00, 1'b0);
    endtask

    task automatic clr_cnt();
        cnt_sell = 0; cnt_chg = 0; cnt_busy = 0; cnt_rej = 0;
    endtask

    initial begin
        clr_cnt();
        #12;
        chk("reset_sell", int'(sell), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_credit", int'(credit), 0);
        rstn = 1'b1;

        // 0.5 + 1 yuan: exact price
        clr_cnt();
        cyc(2'b01, 0); cyc(2'b10, 0); idle(4);
        chk("t1_sell_cnt", cnt_sell, 1);
        chk("t1_chg_cnt", cnt_chg, 0);

        // 1 + 1 yuan: one unit change
        clr_cnt();
        cyc(2'b10, 0); cyc(2'b10, 0); idle(4);
        chk("t2_chg_cnt", cnt_chg, 1);
        chk("t2_busy_cnt", cnt_busy, 2);

        // 5 yuan: seven units change
        clr_cnt();
        cyc(2'b11, 0); idle(10);
        chk("t3_sell_cnt", cnt_sell, 1);
        chk("t3_chg_cnt", cnt_chg, 7);
        chk("t3_busy_cnt", cnt_busy, 8);

        // Coins during payout are rejected and do not disturb it
        clr_cnt();
        cyc(2'b11, 0); cyc(2'b00, 0); cyc(2'b10, 0); cyc(2'b10, 0); idle(9);
        chk("t4_chg_cnt", cnt_chg, 7);
        chk("t4_rej_cnt", cnt_rej, 2);
        chk("t4_sell_cnt", cnt_sell, 1);

        // Cancel together with a coin while holding credit 2
        clr_cnt();
        cyc(2'b01, 0); cyc(2'b01, 0); cyc(2'b10, 1); idle(5);
        chk("t5_sell_cnt", cnt_sell, CANCEL_EN ? 0 : 1);
        chk("t5_chg_cnt", cnt_chg, CANCEL_EN ? 2 : 1);
        chk("t5_rej_cnt", cnt_rej, CANCEL_EN ? 1 : 0);

        // Reset during the third change pulse
        cyc(2'b11, 0); idle(3);
        @(negedge clk);
        chk("t6_pre_chg", int'(chg), 1);
        rstn = 1'b0;
        #1;
        chk("t6_rst_chg", int'(chg), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_sell", int'(sell), 0);
        chk("t6_rst_credit", int'(credit), 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        cyc(2'b01, 0);
        @(negedge clk);
        chk("t6_new_credit", int'(credit), 1);
        check_outputs();
        coin = 2'b00; cancel = 1'b0;
        model_step(2'b00, 1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [1:0] c;
            logic       k;
            c = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            k = ($urandom_range(0, 7) == 0);
            cyc(c, k);
        end
        idle(15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
